fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and hazard controller for the 5-stage pipeline.
- Generalises the EX-stage operand forwarding selects to configurable register-address width.
- Adds load-use stall detection.
- Adds a scoreboard for one multi-cycle execution unit (mul/div) with fixed latency. It generates stalls for RAW dependences and structural conflicts on that unit.
- Sits beside the ID/EX/MEM/WB pipeline registers. Drives the EX operand muxes and the PC/IF-ID freeze + ID/EX bubble.

---
 rtl/fwd_hazard_unit.sv | 136 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding, load-use and multi-cycle (mul/div) hazard control for the 5-stage pipeline.
// Optional FWD_HAZARD_PERF_CNT_EN adds saturating stall-cycle and md-op counters.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_is_md,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic                  ex_mem_read,
  input  logic                  md_start,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_dst,
  input  logic                  wb_reg_write,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  stall,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [REG_ADDR_W-1:0] md_wb_dst,
  output logic                  md_overlap_err
`ifdef FWD_HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [15:0]           md_ops
`endif
);

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b10;
  localparam logic [1:0] FWD_WB      = 2'b11;

  logic [1:0][REG_ADDR_W-1:0] ex_src;
  logic [1:0][1:0]            fwd_sel;

  assign ex_src[0] = ex_rs;
  assign ex_src[1] = ex_rt;

  // MEM holds the younger result, so it wins over WB.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_sel[gi] = FWD_REGFILE;
        if (mem_reg_write && (mem_dst != '0) && (mem_dst == ex_src[gi]))
          fwd_sel[gi] = FWD_MEM;
        else if (wb_reg_write && (wb_dst != '0) && (wb_dst == ex_src[gi]))
          fwd_sel[gi] = FWD_WB;
      end
    end
  endgenerate

  assign fwd_a = fwd_sel[0];
  assign fwd_b = fwd_sel[1];

  logic [3:0]            md_cnt_reg, md_cnt_next;
  logic [REG_ADDR_W-1:0] md_dst_reg, md_dst_next;
  logic                  md_overlap_reg, md_overlap_next;
  logic                  md_accept;

  assign md_accept = md_start && (md_cnt_reg == 4'd0);

  always_comb begin
    md_cnt_next     = md_cnt_reg;
    md_dst_next     = md_dst_reg;
    md_overlap_next = md_overlap_reg;
    if (md_accept) begin
      md_cnt_next = 4'(MD_LATENCY);
      md_dst_next = ex_dst;
    end else if (md_cnt_reg != 4'd0) begin
      md_cnt_next = md_cnt_reg - 4'd1;
    end
    // A start while busy is dropped but remembered until reset.
    if (md_start && (md_cnt_reg != 4'd0))
      md_overlap_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt_reg     <= 4'd0;
      md_dst_reg     <= '0;
      md_overlap_reg <= 1'b0;
    end else begin
      md_cnt_reg     <= md_cnt_next;
      md_dst_reg     <= md_dst_next;
      md_overlap_reg <= md_overlap_next;
    end
  end

  assign md_busy        = (md_cnt_reg != 4'd0);
  assign md_done        = (md_cnt_reg == 4'd1);
  assign md_wb_dst      = md_dst_reg;
  assign md_overlap_err = md_overlap_reg;

  logic load_hz, md_raw, md_struct;

  assign load_hz = ex_mem_read && (ex_dst != '0) &&
                   ((id_uses_rs && (id_rs == ex_dst)) || (id_uses_rt && (id_rt == ex_dst)));

  // Held through md_done: the dependent reads the regfile the cycle after the write.
  assign md_raw = md_busy && (md_dst_reg != '0) &&
                  ((id_uses_rs && (id_rs == md_dst_reg)) || (id_uses_rt && (id_rt == md_dst_reg)));

  // A new md op reaches EX one cycle after leaving ID, when the counter has reached 0.
  assign md_struct = id_is_md && (md_cnt_reg > 4'd1);

  assign stall = load_hz || md_raw || md_struct;

`ifdef FWD_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_reg;
  logic [15:0] md_ops_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_reg <= '0;
      md_ops_reg       <= '0;
    end else begin
      if (stall && !(&stall_cycles_reg))
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (md_accept && !(&md_ops_reg))
        md_ops_reg <= md_ops_reg + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign md_ops       = md_ops_reg;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding priority, load-use, md scoreboard, overlap and async reset.
module tb_fwd_hazard_unit;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic          id_uses_rs, id_uses_rt, id_is_md, ex_mem_read, md_start;
  logic          mem_reg_write, wb_reg_write;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall, md_busy, md_done, md_overlap_err;
  logic [AW-1:0] md_wb_dst;

  int errors = 0;
  int checks = 0;

  fwd_hazard_unit #(.REG_ADDR_W(AW), .MD_LATENCY(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_md(id_is_md), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_mem_read(ex_mem_read), .md_start(md_start), .mem_dst(mem_dst),
    .mem_reg_write(mem_reg_write), .wb_dst(wb_dst), .wb_reg_write(wb_reg_write),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .md_busy(md_busy), .md_done(md_done),
    .md_wb_dst(md_wb_dst), .md_overlap_err(md_overlap_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %-22s obs=%0h exp=%0h", tag, obs, exp);
    end else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0; id_is_md = 0;
    ex_rs = '0; ex_rt = '0; ex_dst = '0; ex_mem_read = 0; md_start = 0;
    mem_dst = '0; mem_reg_write = 0; wb_dst = '0; wb_reg_write = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_done", 32'(md_done), 32'd0);
    chk("rst_wb_dst", 32'(md_wb_dst), 32'd0);
    chk("rst_overlap", 32'(md_overlap_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Forwarding priority
    @(negedge clk);
    mem_reg_write = 1; mem_dst = 8; wb_reg_write = 1; wb_dst = 8; ex_rs = 8; ex_rt = 9;
    #1;
    chk("fwd_a_mem", 32'(fwd_a), 32'd2);
    chk("fwd_b_none", 32'(fwd_b), 32'd0);
    mem_dst = 0; #1;
    chk("fwd_a_wb", 32'(fwd_a), 32'd3);
    wb_dst = 0; #1;
    chk("fwd_a_r0", 32'(fwd_a), 32'd0);
    mem_dst = 9; wb_dst = 8; #1;
    chk("fwd_b_mem", 32'(fwd_b), 32'd2);
    chk("fwd_a_wb2", 32'(fwd_a), 32'd3);
    mem_reg_write = 0; #1;
    chk("fwd_b_nowrite", 32'(fwd_b), 32'd0);
    clear_inputs();

    // Load-use
    @(negedge clk);
    ex_mem_read = 1; ex_dst = 5; id_uses_rt = 1; id_rt = 5; #1;
    chk("load_use", 32'(stall), 32'd1);
    @(negedge clk);
    ex_mem_read = 0; #1;
    chk("load_bubble", 32'(stall), 32'd0);
    ex_mem_read = 1; ex_dst = 0; id_rt = 0; #1;
    chk("load_r0", 32'(stall), 32'd0);
    ex_dst = 5; id_uses_rt = 0; #1;
    chk("load_unused", 32'(stall), 32'd0);
    clear_inputs();

    // MD RAW
    @(negedge clk);
    md_start = 1; ex_dst = 12; #1;
    chk("md_pre_busy", 32'(md_busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      md_start = 0; ex_dst = 0; id_rs = 12; id_uses_rs = 1; #1;
      chk($sformatf("raw_busy_%0d", i), 32'(md_busy), 32'd1);
      chk($sformatf("raw_done_%0d", i), 32'(md_done), (i == 3) ? 32'd1 : 32'd0);
      chk($sformatf("raw_dst_%0d", i), 32'(md_wb_dst), 32'd12);
      chk($sformatf("raw_stall_%0d", i), 32'(stall), 32'd1);
    end
    @(negedge clk); #1;
    chk("raw_idle_busy", 32'(md_busy), 32'd0);
    chk("raw_idle_stall", 32'(stall), 32'd0);
    clear_inputs();

    // MD structural
    @(negedge clk);
    md_start = 1; ex_dst = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      md_start = 0; ex_dst = 0; id_is_md = 1; #1;
      chk($sformatf("struct_stall_%0d", i), 32'(stall), (i < 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    id_is_md = 0; md_start = 1; ex_dst = 7; #1;
    chk("struct_cnt0_busy", 32'(md_busy), 32'd0);
    @(negedge clk);
    md_start = 0; ex_dst = 0; #1;
    chk("second_busy", 32'(md_busy), 32'd1);
    chk("second_dst", 32'(md_wb_dst), 32'd7);
    chk("second_overlap", 32'(md_overlap_err), 32'd0);

    // Overlap at cnt=3
    @(negedge clk);
    md_start = 1; ex_dst = 9;
    @(negedge clk);
    md_start = 0; ex_dst = 0; #1;
    chk("ovl_busy", 32'(md_busy), 32'd1);
    chk("ovl_done", 32'(md_done), 32'd0);
    chk("ovl_dst", 32'(md_wb_dst), 32'd7);
    chk("ovl_err", 32'(md_overlap_err), 32'd1);

    // Async reset at cnt=2
    reset = 1'b0; #1;
    chk("arst_busy", 32'(md_busy), 32'd0);
    chk("arst_done", 32'(md_done), 32'd0);
    chk("arst_overlap", 32'(md_overlap_err), 32'd0);
    chk("arst_dst", 32'(md_wb_dst), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("post_rst_done_%0d", i), 32'(md_done), 32'd0);
      chk($sformatf("post_rst_busy_%0d", i), 32'(md_busy), 32'd0);
    end

    // md with ex_dst=0 runs but never raises a RAW stall
    @(negedge clk);
    md_start = 1; ex_dst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      md_start = 0; id_rs = 0; id_uses_rs = 1; #1;
      chk($sformatf("r0_busy_%0d", i), 32'(md_busy), 32'd1);
      chk($sformatf("r0_done_%0d", i), 32'(md_done), (i == 3) ? 32'd1 : 32'd0);
      chk($sformatf("r0_stall_%0d", i), 32'(stall), 32'd0);
    end
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
